// File: rtl/universal_shift_engine_if.sv
// Command/status bundle between a controller and the shift engine.
// The controller drives the master side; the engine implements the slave side.
interface universal_shift_engine_if #(
  parameter int N = 8
);
  localparam int AW = $clog2(N) + 1;

  logic          start;
  logic [2:0]    op;
  logic [AW-1:0] amount;
  logic          abort;
  logic [N-1:0]  D;
  logic          sin;
  logic [N-1:0]  Q;
  logic          Sout;
  logic          busy;
  logic          done;

  modport master (
    output start, op, amount, abort, D, sin,
    input  Q, Sout, busy, done
  );

  modport slave (
    input  start, op, amount, abort, D, sin,
    output Q, Sout, busy, done
  );
endinterface

// File: rtl/universal_shift_engine.sv
// N-bit shift/rotate engine: bit-serial shifts under a start/busy/done handshake,
// with single-cycle LOAD/CLEAR/NOP and a synchronous abort of running shifts.
module universal_shift_engine #(
  parameter int N = 8
) (
  input logic                      clk,
  input logic                      reset_n,
  universal_shift_engine_if.slave  bus
);
  localparam int AW = $clog2(N) + 1;

  typedef enum logic [2:0] {
    OP_NOP   = 3'b000,
    OP_LOAD  = 3'b001,
    OP_SHL   = 3'b010,
    OP_SHR   = 3'b011,
    OP_ROL   = 3'b100,
    OP_ROR   = 3'b101,
    OP_ASR   = 3'b110,
    OP_CLEAR = 3'b111
  } op_e;

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e        state_q;
  op_e           op_q;
  logic [AW-1:0] cnt_q;
  logic [N-1:0]  q_q;
  logic          done_q;

  op_e           op_d;
  logic [AW-1:0] k_d;
  logic          is_shift_d;
  logic [N-1:0]  step_d;
  logic          sout_d;

  assign op_d       = op_e'(bus.op);
  assign k_d        = (bus.amount > AW'(N)) ? AW'(N) : bus.amount;
  assign is_shift_d = (op_d != OP_NOP) && (op_d != OP_LOAD) && (op_d != OP_CLEAR);

  // One shift step of the latched op; only consumed while in SHIFT.
  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    step_d = q_q;
    sout_d = 1'b0;
    unique case (op_q)
      OP_SHL: step_d = {q_q[N-2:0], bus.sin};
      OP_SHR: step_d = {bus.sin, q_q[N-1:1]};
      OP_ROL: step_d = {q_q[N-2:0], q_q[N-1]};
      OP_ROR: step_d = {q_q[0], q_q[N-1:1]};
      OP_ASR: step_d = {q_q[N-1], q_q[N-1:1]};
      default: step_d = q_q;
    endcase
    if (state_q == SHIFT) begin
      unique case (op_q)
        OP_SHL, OP_ROL:         sout_d = q_q[N-1];
        OP_SHR, OP_ROR, OP_ASR: sout_d = q_q[0];
        default:                sout_d = 1'b0;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      op_q    <= OP_NOP;
      cnt_q   <= '0;
      q_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          // Abort has priority over a start arriving in the same idle cycle.
          if (bus.start && !bus.abort) begin
            unique case (op_d)
              OP_LOAD:  q_q <= bus.D;
              OP_CLEAR: q_q <= '0;
              default:  ;
            endcase
            if (is_shift_d && (k_d != '0)) begin
              state_q <= SHIFT;
              op_q    <= op_d;
              cnt_q   <= k_d;
            end else begin
              done_q  <= 1'b1;
            end
          end
        end
        SHIFT: begin
          if (bus.abort) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            q_q   <= step_d;
            cnt_q <= cnt_q - AW'(1);
            if (cnt_q == AW'(1)) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.Q    = q_q;
  assign bus.Sout = sout_d;
  assign bus.busy = (state_q == SHIFT);
  assign bus.done = done_q;
endmodule

// File: tb/tb_universal_shift_engine.sv
// Randomised and directed bench for universal_shift_engine (N = 8) with a
// done-driven scoreboard checked against an arithmetic reference model.
module tb_universal_shift_engine;
  localparam int N = 8;

  logic clk;
  logic reset_n;
  int   cyc;
  int   n_tests;
  int   n_fail;
  logic [7:0] model_q;

  typedef struct {
    logic [7:0] q;
    int         cyc;
  } exp_t;
  exp_t sb[$];

  universal_shift_engine_if #(.N(N)) bus ();

  universal_shift_engine #(.N(N)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Whole-command reference: the effect of k steps, computed directly.
  function automatic logic [7:0] model(input logic [2:0] o, input int k, input logic [7:0] q,
                                       input logic [7:0] d, input logic s);
    int v;
    int r;
    int sv;
    v = int'(q);
    case (o)
      3'd0: r = v;
      3'd1: r = int'(d);
      3'd2: r = (v << k) | (s ? ((1 << k) - 1) : 0);
      3'd3: r = (v >> k) | (s ? (255 << (8 - k)) : 0);
      3'd4: r = (v << k) | (v >> (8 - k));
      3'd5: r = (v >> k) | (v << (8 - k));
      3'd6: begin
        sv = (v >= 128) ? v - 256 : v;
        r  = sv >>> k;
      end
      default: r = 0;
    endcase
    return r[7:0];
  endfunction

  // Monitor: every done pulse must match the oldest expected completion.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n && bus.done) begin
      if (sb.size() == 0) begin
        check("done_unexpected", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("done_q", 32'(bus.Q), 32'(e.q));
        check("done_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 32'(bus.busy), 32'd0);
  endtask

  // Issues one accepted command at a negedge; returns at the negedge after the accept edge.
  task automatic cmd(input logic [2:0] o, input int amt, input logic [7:0] d, input logic s,
                     input bit track);
    int   k;
    exp_t e;
    wait_idle();
    k          = (amt > N) ? N : amt;
    bus.start  = 1'b1;
    bus.op     = o;
    bus.amount = amt[3:0];
    bus.D      = d;
    bus.sin    = s;
    if (track) begin
      model_q = model(o, k, model_q, d, s);
      e.q     = model_q;
      e.cyc   = cyc + 1 + ((o >= 3'd2 && o <= 3'd6) ? k : 0);
      sb.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  initial begin
    int busy_cnt;
    int k;
    logic [2:0] o;
    int amt;
    n_tests    = 0;
    n_fail     = 0;
    model_q    = 8'h00;
    reset_n    = 1'b0;
    bus.start  = 1'b0;
    bus.op     = 3'b000;
    bus.amount = '0;
    bus.abort  = 1'b0;
    bus.D      = '0;
    bus.sin    = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    check("reset_q", 32'(bus.Q), 32'h00);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);

    // LOAD: immediate, busy never set
    cmd(3'b001, 0, 8'hA5, 1'b0, 1'b1);
    check("load_busy", 32'(bus.busy), 32'd0);
    check("load_q", 32'(bus.Q), 32'hA5);

    // SHL 3 with sin = 1, stepwise Q and Sout
    cmd(3'b010, 3, 8'h00, 1'b1, 1'b1);
    check("shl_busy0", 32'(bus.busy), 32'd1);
    check("shl_q0", 32'(bus.Q), 32'hA5);
    check("shl_sout0", 32'(bus.Sout), 32'd1);
    @(negedge clk);
    check("shl_q1", 32'(bus.Q), 32'h4B);
    check("shl_sout1", 32'(bus.Sout), 32'd0);
    @(negedge clk);
    check("shl_q2", 32'(bus.Q), 32'h97);
    check("shl_sout2", 32'(bus.Sout), 32'd1);
    @(negedge clk);
    check("shl_q3", 32'(bus.Q), 32'h2F);
    check("shl_busy3", 32'(bus.busy), 32'd0);
    check("sout_idle", 32'(bus.Sout), 32'd0);

    // ASR 2 from 90, then SHR 2 from 90 with sin = 0
    cmd(3'b001, 0, 8'h90, 1'b0, 1'b1);
    cmd(3'b110, 2, 8'h00, 1'b0, 1'b1);
    check("asr_sout0", 32'(bus.Sout), 32'd0);
    @(negedge clk);
    check("asr_q1", 32'(bus.Q), 32'hC8);
    check("asr_sout1", 32'(bus.Sout), 32'd0);
    @(negedge clk);
    check("asr_q2", 32'(bus.Q), 32'hE4);
    cmd(3'b001, 0, 8'h90, 1'b0, 1'b1);
    cmd(3'b011, 2, 8'h00, 1'b0, 1'b1);
    wait_idle();
    check("shr_q", 32'(bus.Q), 32'h24);

    // ROR by 8, by 12 (clamped) and by 0
    cmd(3'b001, 0, 8'h3C, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      cmd(3'b101, (i == 0) ? 8 : 12, 8'h00, 1'b0, 1'b1);
      busy_cnt = 0;
      while (bus.busy && busy_cnt < 20) begin
        busy_cnt++;
        @(negedge clk);
      end
      check("ror_busy_cycles", busy_cnt, 8);
      check("ror_q", 32'(bus.Q), 32'h3C);
    end
    cmd(3'b101, 0, 8'h00, 1'b0, 1'b1);
    check("ror0_busy", 32'(bus.busy), 32'd0);

    // Abort after two SHR steps; a start during busy must be ignored
    cmd(3'b001, 0, 8'hF0, 1'b0, 1'b1);
    cmd(3'b011, 5, 8'h00, 1'b0, 1'b0);
    bus.start  = 1'b1;
    bus.op     = 3'b011;
    bus.amount = 4'd1;
    bus.D      = 8'hFF;
    @(negedge clk);
    bus.start = 1'b0;
    check("abort_q1", 32'(bus.Q), 32'h78);
    check("abort_busy1", 32'(bus.busy), 32'd1);
    @(negedge clk);
    check("abort_q2", 32'(bus.Q), 32'h3C);
    check("abort_busy2", 32'(bus.busy), 32'd1);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort_q", 32'(bus.Q), 32'h3C);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    model_q = model(3'b011, 2, 8'hF0, 8'h00, 1'b0);

    // Abort while idle blocks a simultaneous start
    bus.abort = 1'b1;
    cmd(3'b001, 0, 8'h11, 1'b0, 1'b0);
    bus.abort = 1'b0;
    check("idle_abort_q", 32'(bus.Q), 32'(model_q));
    check("idle_abort_busy", 32'(bus.busy), 32'd0);

    // Asynchronous reset in the middle of a shift
    cmd(3'b001, 0, 8'h5A, 1'b0, 1'b1);
    cmd(3'b010, 5, 8'h00, 1'b1, 1'b0);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midreset_q", 32'(bus.Q), 32'h00);
    check("midreset_busy", 32'(bus.busy), 32'd0);
    check("midreset_done", 32'(bus.done), 32'd0);
    #1;
    reset_n = 1'b1;
    model_q = 8'h00;
    @(negedge clk);

    // Randomised command stream against the reference model
    for (int i = 0; i < 150; i++) begin
      o   = 3'($urandom_range(0, 7));
      amt = $urandom_range(0, 15);
      k   = (amt > N) ? N : amt;
      cmd(o, amt, 8'($urandom), 1'($urandom), 1'b1);
      check("rand_busy", 32'(bus.busy), 32'((o >= 3'd2 && o <= 3'd6 && k > 0) ? 1 : 0));
    end

    wait_idle();
    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    check("final_q", 32'(bus.Q), 32'(model_q));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
